// File: rtl/register_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN (see register_scoreboard.sv).
package register_scoreboard_pkg;

   // ---- BasicTypes ----
   localparam int REG_NUM    = 32;
   localparam int REG_ADDR_W = $clog2(REG_NUM);
   typedef logic [REG_ADDR_W-1:0] RegNumPath;

   // ---- PipelineTypes ----
   localparam int CNT_W         = 2;
   localparam int SCORE_CNT_MAX = (1 << CNT_W) - 1;
   typedef logic [CNT_W-1:0] ScoreCountPath;

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode/writeback <-> scoreboard signal bundle.
// master = decode/hazard side, slave = scoreboard.
interface register_scoreboard_if;
   import register_scoreboard_pkg::*;

   logic      issueValid;
   logic      issueWrite;
   RegNumPath issueRd;
   logic      stall;
   logic      wbValid;
   RegNumPath wbRd;
   logic      flush;
   RegNumPath rs1Addr;
   RegNumPath rs2Addr;
   logic      rs1Ready;
   logic      rs2Ready;
   logic      rdFull;

   modport master (
      output issueValid, issueWrite, issueRd, stall,
      output wbValid, wbRd, flush, rs1Addr, rs2Addr,
      input  rs1Ready, rs2Ready, rdFull
   );

   modport slave (
      input  issueValid, issueWrite, issueRd, stall,
      input  wbValid, wbRd, flush, rs1Addr, rs2Addr,
      output rs1Ready, rs2Ready, rdFull
   );

endinterface

// File: rtl/scoreboard_counter.sv
// One saturating up/down pending-write counter for a single register.
// Simultaneous inc and dec cancel; clear wins over both.
module scoreboard_counter
   import register_scoreboard_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   input  logic          clear,
   output ScoreCountPath cnt,
   output logic          isZero,
   output logic          isFull
);

   ScoreCountPath cntNext;

   assign isZero = (cnt == '0);
   assign isFull = (cnt == ScoreCountPath'(SCORE_CNT_MAX));

   // Next count: clear, else a single-sided step that never wraps.
   always_comb begin
      cntNext = cnt;
      if (clear)
         cntNext = '0;
      else if (inc && !dec && !isFull)
         cntNext = cnt + ScoreCountPath'(1);
      else if (dec && !inc && !isZero)
         cntNext = cnt - ScoreCountPath'(1);
   end

   // Counter state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cntNext;
   end

endmodule

// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard for the decode stage.
// Produces rs1Ready/rs2Ready for hazard detection and rdFull to stall issue
// before a counter would saturate.
// Optional feature: `define SCOREBOARD_WB_BYPASS_EN lets a source become ready
// in the cycle its last outstanding write is retiring (regfile write-through).
module register_scoreboard
   import register_scoreboard_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   register_scoreboard_if.slave  sb
);

   logic [REG_NUM-1:0][CNT_W-1:0] cnt;
   logic [REG_NUM-1:0]            isZero;
   logic [REG_NUM-1:0]            isFull;

   logic issueFire;
   logic wbFire;
   logic rs1Clear;
   logic rs2Clear;

   // x0 never has a pending write.
   assign cnt[0]    = '0;
   assign isZero[0] = 1'b1;
   assign isFull[0] = 1'b0;

   assign sb.rdFull = isFull[sb.issueRd] & sb.issueWrite & (sb.issueRd != '0);

   assign issueFire = sb.issueValid & sb.issueWrite & ~sb.stall & ~sb.rdFull
                    & ~sb.flush & (sb.issueRd != '0);

   // A writeback to a register with nothing pending is dropped (no underflow).
   assign wbFire = sb.wbValid & (sb.wbRd != '0) & ~isZero[sb.wbRd];

   for (genvar r = 1; r < REG_NUM; r++) begin : gCnt
      logic incR;
      logic decR;
      assign incR = issueFire & (sb.issueRd == RegNumPath'(r));
      assign decR = wbFire    & (sb.wbRd    == RegNumPath'(r));

      scoreboard_counter uCnt (
         .clk    (clk),
         .rst    (rst),
         .inc    (incR),
         .dec    (decR),
         .clear  (sb.flush),
         .cnt    (cnt[r]),
         .isZero (isZero[r]),
         .isFull (isFull[r])
      );
   end

   // Source readiness: nothing pending, or (bypass) the last write retires now.
   always_comb begin
      rs1Clear = (cnt[sb.rs1Addr] == '0);
      rs2Clear = (cnt[sb.rs2Addr] == '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (sb.wbValid && (sb.wbRd == sb.rs1Addr) && (cnt[sb.rs1Addr] == ScoreCountPath'(1)))
         rs1Clear = 1'b1;
      if (sb.wbValid && (sb.wbRd == sb.rs2Addr) && (cnt[sb.rs2Addr] == ScoreCountPath'(1)))
         rs2Clear = 1'b1;
`endif
      sb.rs1Ready = (sb.rs1Addr == '0) | rs1Clear;
      sb.rs2Ready = (sb.rs2Addr == '0) | rs2Clear;
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios followed by
// randomized traffic, all checked against an array-of-integers model.
module tb_register_scoreboard;
   import register_scoreboard_pkg::*;

   localparam int MAXC = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   register_scoreboard_if sbIf();

   register_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (sbIf.slave)
   );

   int m[REG_NUM];
   int passCnt  = 0;
   int totalCnt = 0;

   function automatic bit expReady(int a);
      if (a == 0) return 1'b1;
      if (m[a] == 0) return 1'b1;
      if (BYP && sbIf.wbValid && int'(sbIf.wbRd) == a && m[a] == 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit expFull();
      return sbIf.issueWrite && sbIf.issueRd != 0 && m[sbIf.issueRd] == MAXC;
   endfunction

   task automatic checkBit(string tag, logic obs, logic exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
   endtask

   task automatic checkOutputs(string tag);
      checkBit({tag, "/rs1Ready"}, sbIf.rs1Ready, expReady(int'(sbIf.rs1Addr)));
      checkBit({tag, "/rs2Ready"}, sbIf.rs2Ready, expReady(int'(sbIf.rs2Addr)));
      checkBit({tag, "/rdFull"},   sbIf.rdFull,   expFull());
   endtask

   task automatic idle();
      sbIf.issueValid = 0; sbIf.issueWrite = 0; sbIf.issueRd = '0; sbIf.stall = 0;
      sbIf.wbValid = 0; sbIf.wbRd = '0; sbIf.flush = 0;
      sbIf.rs1Addr = '0; sbIf.rs2Addr = '0;
   endtask

   task automatic issue(int rd);
      sbIf.issueValid = 1; sbIf.issueWrite = 1; sbIf.issueRd = RegNumPath'(rd);
   endtask

   task automatic wb(int rd);
      sbIf.wbValid = 1; sbIf.wbRd = RegNumPath'(rd);
   endtask

   // Inputs are set right after a falling edge; check outputs, advance the
   // model with this cycle's inputs, then cross the rising edge.
   task automatic tick(string tag);
      int  rd;
      int  wr;
      bit  iss;
      bit  wbk;
      #1;
      checkOutputs(tag);
      rd  = int'(sbIf.issueRd);
      wr  = int'(sbIf.wbRd);
      iss = sbIf.issueValid && sbIf.issueWrite && !sbIf.stall && !expFull()
            && rd != 0 && !sbIf.flush;
      wbk = sbIf.wbValid && wr != 0 && m[wr] > 0;
      if (!rst) begin
         if (sbIf.flush) begin
            for (int i = 0; i < REG_NUM; i++) m[i] = 0;
         end else begin
            if (iss) m[rd] = m[rd] + 1;
            if (wbk) m[wr] = m[wr] - 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < REG_NUM; i++) m[i] = 0;
      idle();
      @(negedge clk);
      sbIf.rs1Addr = 5'd1; sbIf.rs2Addr = 5'd31;
      tick("in_reset");
      rst = 0;
      tick("reset_state");

      // Issue then read-after-write
      idle(); issue(3); tick("raw_issue");
      idle(); sbIf.rs1Addr = 3; tick("raw_c1");
      tick("raw_c2");
      tick("raw_c3");
      wb(3); tick("raw_wb_cycle");
      idle(); sbIf.rs1Addr = 3; tick("raw_after_wb");

      // Simultaneous issue and writeback to the same register
      idle(); issue(7); tick("same_setup");
      issue(7); wb(7); sbIf.rs2Addr = 7; tick("same_cycle");
      idle(); sbIf.rs2Addr = 7; tick("same_after");

      // Saturation
      idle(); issue(9); tick("sat_i1");
      tick("sat_i2");
      tick("sat_i3");
      sbIf.rs1Addr = 9; tick("sat_blocked");
      idle(); wb(9); sbIf.issueWrite = 1; sbIf.issueRd = 9; tick("sat_wb");
      idle(); sbIf.issueWrite = 1; sbIf.issueRd = 9; sbIf.rs1Addr = 9; tick("sat_relieved");

      // Stall suppresses issue
      idle(); issue(4); sbIf.stall = 1; tick("stall_issue");
      idle(); sbIf.rs1Addr = 4; tick("stall_after");

      // x0 is never pending
      idle(); issue(0); sbIf.rs1Addr = 0; tick("x0_issue");
      idle(); sbIf.rs1Addr = 0; sbIf.rs2Addr = 0; sbIf.issueWrite = 1; tick("x0_after");

      // Flush discards pending state and same-cycle traffic
      idle(); issue(2); tick("fl_i2a");
      tick("fl_i2b");
      issue(6); tick("fl_i6");
      idle(); sbIf.rs1Addr = 2; sbIf.rs2Addr = 6; tick("fl_pre");
      issue(5); wb(2); sbIf.flush = 1; tick("fl_flush");
      idle(); sbIf.rs1Addr = 2; sbIf.rs2Addr = 6; tick("fl_post");
      wb(2); tick("fl_late_wb");
      idle(); sbIf.rs1Addr = 2; sbIf.rs2Addr = 5;
      sbIf.issueWrite = 1; sbIf.issueRd = 2; tick("fl_no_wrap");

      // Underflow guard
      idle(); wb(11); sbIf.rs1Addr = 11; tick("uf_wb");
      idle(); sbIf.rs1Addr = 11; sbIf.issueWrite = 1; sbIf.issueRd = 11; tick("uf_after");

      // Asynchronous reset mid-run
      idle(); issue(5); tick("ar_i1");
      tick("ar_i2");
      idle(); sbIf.rs1Addr = 5;
      #1;
      checkBit("ar_pre/rs1Ready", sbIf.rs1Ready, expReady(5));
      rst = 1;
      for (int i = 0; i < REG_NUM; i++) m[i] = 0;
      #1;
      checkBit("ar_async/rs1Ready", sbIf.rs1Ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      tick("ar_released");

      // Randomized traffic concentrated on a few registers
      for (int n = 0; n < 400; n++) begin
         sbIf.issueValid = 1'($urandom_range(0, 1));
         sbIf.issueWrite = 1'($urandom_range(0, 3) != 0);
         sbIf.issueRd    = RegNumPath'($urandom_range(0, 3));
         sbIf.stall      = 1'($urandom_range(0, 3) == 0);
         sbIf.wbValid    = 1'($urandom_range(0, 2) == 0);
         sbIf.wbRd       = RegNumPath'($urandom_range(0, 3));
         sbIf.flush      = 1'($urandom_range(0, 39) == 0);
         sbIf.rs1Addr    = RegNumPath'($urandom_range(0, 4));
         sbIf.rs2Addr    = RegNumPath'($urandom_range(0, 4));
         tick("rand");
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
Tracks in-flight writes to each architectural integer register. Produces the per-operand ready flags (rs1Ready/rs2Ready) that the hazard controller combines with operand types to raise isDataHazard. Sits beside the register file in the decode stage. It is updated by the decode/issue handshake and by writeback.

Parameters:
REG_NUM, 32, number of architectural registers (x0 included).
REG_ADDR_W, 5, register index width, equal to $clog2(REG_NUM).
CNT_W, 2, width of per-register pending-write counter. Max in-flight writes per register is 2^CNT_W-1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
issueValid  in  1  decode holds a valid instruction this cycle
issueWrite  in  1  that instruction writes rd
issueRd  in  REG_ADDR_W  destination register of issuing instruction
stall  in  1  decode stalled this cycle (hazard or backpressure); suppresses issue
wbValid  in  1  a register write retires this cycle
wbRd  in  REG_ADDR_W  register written at writeback
flush  in  1  pipeline flush; clears all pending state
rs1Addr  in  REG_ADDR_W  source 1 index of decoding instruction
rs2Addr  in  REG_ADDR_W  source 2 index of decoding instruction
rs1Ready  out  1  source 1 has no pending write
rs2Ready  out  1  source 2 has no pending write
rdFull  out  1  counter of issueRd is saturated; decode must stall

Behaviour:
- Reset: asynchronous on rst high. All counters become 0. Outputs then read rs1Ready=1, rs2Ready=1, rdFull=0.
- issueFire = issueValid & issueWrite & ~stall & ~rdFull & ~flush & (issueRd != 0).
- wbFire = wbValid & (wbRd != 0) & (cnt[wbRd] != 0). A writeback to a zero counter is ignored, so there is no underflow.
- Register update on posedge clk, per entry r:
  - flush=1: cnt[r] <= 0, regardless of issue or writeback.
  - issueFire to r only: cnt[r] <= cnt[r]+1.
  - wbFire to r only: cnt[r] <= cnt[r]-1.
  - Both to the same r in the same cycle: unchanged.
- Issue takes effect the next cycle. A dependent instruction decoded the cycle after the producer issues sees ready=0.
- rsXReady is combinational:
  - 1 if rsXAddr == 0.
  - Otherwise (cnt[rsXAddr] == 0), or the writeback bypass term when the optional feature is enabled.
- rdFull is combinational: (cnt[issueRd] == 2^CNT_W-1) & issueWrite & (issueRd != 0). No saturation wrap is ever permitted.
- x0: its counter is constant 0, never written, and always ready.
- Flush discards any same-cycle issue and writeback. Writebacks arriving after a flush to a now-zero counter are ignored.
- rst mid-operation clears state immediately, with no clock needed.
- There is no FSM. State is REG_NUM saturating up/down counters.

Optional Feature:
Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: rsXReady is also 1 when all of the following hold:
  - wbValid=1
  - wbRd == rsXAddr != 0
  - cnt[rsXAddr] == 1
  This lets a source resolve in the writeback cycle, with the register file providing write-through.
- Undefined: ready only when the counter is already 0, i.e. one extra stall cycle after writeback.

Decomposition:
- BasicTypes gets:
  - RegNumPath typedef (logic [REG_ADDR_W-1:0])
  - REG_NUM and REG_ADDR_W constants
- PipelineTypes gets:
  - ScoreCountPath typedef (logic [CNT_W-1:0])
  - SCORE_CNT_MAX constant
- One natural sub-module, scoreboard_counter: a single saturating up/down counter with inc, dec, clear, and a zero/full status. It is instantiated REG_NUM-1 times by generate.

Test Plan:
- Reset: assert rst mid-run with cnt[5]=2 -> rs1Addr=5 gives rs1Ready=1 immediately, without a clock edge.
- Issue then read-after-write: issue rd=3 at cycle 0 -> cycle 1, rs1Addr=3 gives rs1Ready=0; wb rd=3 at cycle 4 -> cycle 5 gives rs1Ready=1. With bypass: rs1Ready=1 already in cycle 4.
- Simultaneous issue and writeback to the same register: cnt[7]=1; issue rd=7 and wb rd=7 in the same cycle -> cnt[7] stays 1, rs2Ready=0.
- Saturation: issue rd=9 three times (CNT_W=2) -> rdFull=1 and a fourth issue is blocked. After one wb rd=9, rdFull=0.
- Stall, flush and x0:
  - stall=1 with issueValid, rd=4 -> cnt[4] unchanged.
  - issue rd=0 -> always ready.
  - flush with cnt[2]=2, cnt[6]=1 -> all ready next cycle; a later wb rd=2 is ignored.
- Underflow guard: wb rd=11 with cnt[11]=0 -> cnt stays 0, rs1Ready=1, no wrap to 3.
